ooo_dispatch_ctrl: RTL and testbench
====================================

Name: ooo_dispatch_ctrl

Overview:
- Parametrised WIDTH-lane in-order dispatch controller between the rename/decode register and the reservation station (RS) and ROB.
- Allocates ROB indices and stalls when the ROB lacks space.
- Tracks per-physical-register ready bits, with wakeup from writeback and intra-group dependency detection.
- Assigns functional units: ALUs round-robin, memory ops to the memory FU.
- Adds to single-pair dispatch: backpressure, commit-driven free space, wakeup bypass and flush.

Parameters:
- WIDTH, 2: dispatch lanes per cycle (1..4).
- PREGS, 64: number of physical registers; PRW = $clog2(PREGS).
- ROB_DEPTH, 16: ROB entries, power of 2; RW = $clog2(ROB_DEPTH).
- NUM_ALU, 2: ALU FUs; memory FU id = NUM_ALU; FW = $clog2(NUM_ALU+1).
- WB_PORTS, 2: writeback/wakeup ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  WIDTH  lane valid; lane 0 is oldest
- in_rd / in_rs1 / in_rs2  in  WIDTH*PRW each  physical dest/sources per lane
- in_writes_rd  in  WIDTH  lane writes rd (0 for stores/branches)
- in_uses_imm  in  WIDTH  rs2 replaced by immediate
- in_is_mem  in  WIDTH  load/store lane
- in_ready  out  1  group accepted this cycle
- out_valid  out  WIDTH  registered RS/ROB write enables
- out_rob_idx  out  WIDTH*RW  ROB index per lane
- out_fu  out  WIDTH*FW  FU id per lane
- out_src1_rdy / out_src2_rdy  out  WIDTH each  source ready at dispatch
- wb_valid  in  WB_PORTS  wakeup valid
- wb_preg  in  WB_PORTS*PRW  woken physical register
- commit_cnt  in  $clog2(WIDTH+1)  ROB entries retired this cycle
- flush  in  1  squash all in-flight state
- rob_free  out  RW+1  free ROB entries (registered)

Behaviour:
- Reset (clk, reset sync active-high): head=tail=0, rob_free=ROB_DEPTH, alu_ptr=0, all PREGS ready bits=1, all outputs 0.
- Accept condition: n = popcount(in_valid). Valid lanes must be contiguous from lane 0; a gap is unsupported (assertion).
  - in_ready = (rob_free >= n) && !flush. Combinational, from registered rob_free.
  - All-or-nothing: a partial group is never dispatched.
- Latency: accepted group appears on out_* exactly 1 cycle later. out_valid[i] = in_valid[i] of the accepted group; otherwise 0 for 1 cycle.
- ROB allocation: lane i gets index (tail + i) mod ROB_DEPTH, with i counted over valid lanes. On accept, tail += n (wraps).
- Free count: rob_free_next = rob_free - (accepted ? n : 0) + commit_cnt, evaluated in the same cycle. head += commit_cnt.
  - commit_cnt > occupancy is illegal (assertion).
- Readiness per source:
  - rdy = scoreboard[src] OR (any wb_valid[k] && wb_preg[k]==src).
  - Forced 0 if an older lane j<i in the same group has in_writes_rd[j] && in_rd[j]==src.
  - src2 forced 1 when in_uses_imm.
  - preg 0 is always ready.
- Scoreboard update:
  - wakeup sets bit.
  - accepted lane with in_writes_rd clears bit in_rd (preg 0 never cleared).
  - Same preg set and cleared in one cycle: clear wins.
- FU assignment:
  - in_is_mem lanes get FU NUM_ALU.
  - Non-mem lanes take (alu_ptr + k) mod NUM_ALU, where k = rank among non-mem lanes of the group.
  - On accept, alu_ptr advances by the non-mem count mod NUM_ALU.
  - A stalled group does not advance alu_ptr.
- Flush (priority over accept and commit):
  - next cycle tail=head, rob_free=ROB_DEPTH, out_valid=0, all ready bits=1.
  - alu_ptr unchanged.
  - Same-cycle input is not accepted.
- Reset during active dispatch: out_valid=0 next cycle; no partial state survives.
- Full: rob_free=0 → in_ready=0 even for n=1. Same-cycle commit frees space only from the next cycle.
- Empty input (n=0): in_ready=1, no state change except wakeup/commit.

Optional Feature:
- Macro DISPATCH_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt (32-bit), counting cycles with n>0 && !in_ready && !flush.
  - Saturates at 0xFFFFFFFF; cleared by reset only.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset then 8 consecutive 2-lane ALU groups, commit_cnt=0:
  - ROB indices 0,1..15,14→15; rob_free hits 0.
  - 9th group: in_ready=0.
  - FU ids alternate 0,1.
- Full ROB, commit_cnt=2, group n=2 held:
  - in_ready=0 that cycle, 1 next cycle.
  - Indices 0,1 (wrapped).
- Lane0 rd=5 writes, lane1 rs1=5: lane1 src1_rdy=0. Then wb_preg=5: subsequent lane reading 5 gets rdy=1 in the same cycle as the wakeup.
- Same cycle: wb_preg=9 and an accepted lane allocating rd=9 → scoreboard[9]=0 afterwards.
- Group {mem, alu} with alu_ptr=1 → out_fu={2,1}; alu_ptr becomes 0.
- After 5 dispatched entries, assert flush with in_valid=2'b11:
  - in_ready=0; next cycle out_valid=0, rob_free=16, all sources ready.

Source files
------------

// File: rtl/ooo_dispatch_ctrl.sv
// In-order WIDTH-lane dispatch controller: ROB index allocation, per-preg ready scoreboard, FU steering.
// Defining DISPATCH_PERF_EN adds the perf_stall_cnt output (saturating count of ROB-space stall cycles).

module ooo_dispatch_ctrl_chk #(
    parameter int WIDTH     = 2,
    parameter int ROB_DEPTH = 16,
    parameter int RW        = 4,
    parameter int CW        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_valid,
    input  logic [CW-1:0]    commit_cnt,
    input  logic [RW:0]      rob_free
);
    logic [WIDTH-1:0] valid_plus1_s;

    assign valid_plus1_s = in_valid + WIDTH'(1);

    // Valid lanes must form a contiguous run starting at lane 0.
    a_contig: assert property (@(posedge clk) disable iff (reset)
        ((in_valid & valid_plus1_s) == {WIDTH{1'b0}}));

    // Retirement can never exceed what is currently allocated.
    a_commit: assert property (@(posedge clk) disable iff (reset)
        (int'(commit_cnt) <= (ROB_DEPTH - int'(rob_free))));
endmodule

module ooo_dispatch_ctrl #(
    parameter int WIDTH     = 2,
    parameter int PREGS     = 64,
    parameter int ROB_DEPTH = 16,
    parameter int NUM_ALU   = 2,
    parameter int WB_PORTS  = 2,
    localparam int PRW   = $clog2(PREGS),
    localparam int RW    = $clog2(ROB_DEPTH),
    localparam int FW    = $clog2(NUM_ALU + 1),
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int FREEW = RW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_valid,
    input  logic [WIDTH*PRW-1:0]    in_rd,
    input  logic [WIDTH*PRW-1:0]    in_rs1,
    input  logic [WIDTH*PRW-1:0]    in_rs2,
    input  logic [WIDTH-1:0]        in_writes_rd,
    input  logic [WIDTH-1:0]        in_uses_imm,
    input  logic [WIDTH-1:0]        in_is_mem,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_valid,
    output logic [WIDTH*RW-1:0]     out_rob_idx,
    output logic [WIDTH*FW-1:0]     out_fu,
    output logic [WIDTH-1:0]        out_src1_rdy,
    output logic [WIDTH-1:0]        out_src2_rdy,
    input  logic [WB_PORTS-1:0]     wb_valid,
    input  logic [WB_PORTS*PRW-1:0] wb_preg,
    input  logic [CW-1:0]           commit_cnt,
    input  logic                    flush,
    output logic [RW:0]             rob_free
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt
`endif
);
    logic [RW-1:0]       head_r;
    logic [RW-1:0]       tail_r;
    logic [FREEW-1:0]    rob_free_r;
    logic [FW-1:0]       alu_ptr_r;
    logic [PREGS-1:0]    sb_r;
    logic [WIDTH-1:0]    out_valid_r;
    logic [WIDTH*RW-1:0] out_rob_idx_r;
    logic [WIDTH*FW-1:0] out_fu_r;
    logic [WIDTH-1:0]    out_src1_rdy_r;
    logic [WIDTH-1:0]    out_src2_rdy_r;

    logic [CW-1:0]       n_s;
    logic [CW-1:0]       alu_cnt_s;
    logic                in_ready_s;
    logic [PREGS-1:0]    wake_s;
    logic [PREGS-1:0]    sb_next_s;
    logic [WIDTH*RW-1:0] rob_idx_s;
    logic [WIDTH*FW-1:0] fu_s;
    logic [WIDTH-1:0]    src1_rdy_s;
    logic [WIDTH-1:0]    src2_rdy_s;
    logic                dep1_s;
    logic                dep2_s;
    logic [FREEW-1:0]    rob_free_next_s;
    logic [FW-1:0]       alu_ptr_next_s;

    // Wakeup vector: every preg named by a valid writeback port this cycle.
    always_comb begin
        wake_s = {PREGS{1'b0}};
        for (int k = 0; k < WB_PORTS; k++) begin
            wake_s[wb_preg[k*PRW +: PRW]] = wake_s[wb_preg[k*PRW +: PRW]] | wb_valid[k];
        end
    end

    // Group decode: lane count, ROB indices, FU ids and source readiness.
    always_comb begin
        n_s        = {CW{1'b0}};
        alu_cnt_s  = {CW{1'b0}};
        rob_idx_s  = {(WIDTH*RW){1'b0}};
        fu_s       = {(WIDTH*FW){1'b0}};
        src1_rdy_s = {WIDTH{1'b0}};
        src2_rdy_s = {WIDTH{1'b0}};
        dep1_s     = 1'b0;
        dep2_s     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            n_s = n_s + CW'(in_valid[i]);
            rob_idx_s[i*RW +: RW] = tail_r + RW'(i);
            if (!in_valid[i]) begin
                fu_s[i*FW +: FW] = {FW{1'b0}};
            end else if (in_is_mem[i]) begin
                fu_s[i*FW +: FW] = FW'(NUM_ALU);
            end else begin
                fu_s[i*FW +: FW] = FW'((int'(alu_ptr_r) + int'(alu_cnt_s)) % NUM_ALU);
                alu_cnt_s = alu_cnt_s + CW'(1);
            end
            // An older lane of the same group producing this source hides the scoreboard bit.
            dep1_s = 1'b0;
            dep2_s = 1'b0;
            for (int j = 0; j < i; j++) begin
                dep1_s = dep1_s | (in_valid[j] & in_writes_rd[j] &
                                   (in_rd[j*PRW +: PRW] == in_rs1[i*PRW +: PRW]));
                dep2_s = dep2_s | (in_valid[j] & in_writes_rd[j] &
                                   (in_rd[j*PRW +: PRW] == in_rs2[i*PRW +: PRW]));
            end
            src1_rdy_s[i] = (in_rs1[i*PRW +: PRW] == {PRW{1'b0}}) |
                            (~dep1_s & (sb_r[in_rs1[i*PRW +: PRW]] | wake_s[in_rs1[i*PRW +: PRW]]));
            src2_rdy_s[i] = in_uses_imm[i] | (in_rs2[i*PRW +: PRW] == {PRW{1'b0}}) |
                            (~dep2_s & (sb_r[in_rs2[i*PRW +: PRW]] | wake_s[in_rs2[i*PRW +: PRW]]));
        end
        in_ready_s      = !flush && (int'(rob_free_r) >= int'(n_s));
        alu_ptr_next_s  = FW'((int'(alu_ptr_r) + int'(alu_cnt_s)) % NUM_ALU);
        rob_free_next_s = FREEW'(int'(rob_free_r) - (in_ready_s ? int'(n_s) : 0) + int'(commit_cnt));
    end

    // Scoreboard next state: wakeups set, accepted destinations clear (clear wins), preg 0 pinned ready.
    always_comb begin
        sb_next_s = sb_r | wake_s;
        for (int i = 0; i < WIDTH; i++) begin
            sb_next_s[in_rd[i*PRW +: PRW]] = sb_next_s[in_rd[i*PRW +: PRW]] &
                                             ~(in_ready_s & in_valid[i] & in_writes_rd[i]);
        end
        sb_next_s[0] = 1'b1;
    end

    // ROB pointers, free count, ALU pointer, scoreboard and registered dispatch outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r         <= {RW{1'b0}};
            tail_r         <= {RW{1'b0}};
            rob_free_r     <= FREEW'(ROB_DEPTH);
            alu_ptr_r      <= {FW{1'b0}};
            sb_r           <= {PREGS{1'b1}};
            out_valid_r    <= {WIDTH{1'b0}};
            out_rob_idx_r  <= {(WIDTH*RW){1'b0}};
            out_fu_r       <= {(WIDTH*FW){1'b0}};
            out_src1_rdy_r <= {WIDTH{1'b0}};
            out_src2_rdy_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            tail_r         <= head_r;
            rob_free_r     <= FREEW'(ROB_DEPTH);
            sb_r           <= {PREGS{1'b1}};
            out_valid_r    <= {WIDTH{1'b0}};
            out_rob_idx_r  <= {(WIDTH*RW){1'b0}};
            out_fu_r       <= {(WIDTH*FW){1'b0}};
            out_src1_rdy_r <= {WIDTH{1'b0}};
            out_src2_rdy_r <= {WIDTH{1'b0}};
        end else begin
            head_r     <= head_r + RW'(commit_cnt);
            rob_free_r <= rob_free_next_s;
            sb_r       <= sb_next_s;
            if (in_ready_s) begin
                tail_r         <= tail_r + RW'(n_s);
                alu_ptr_r      <= alu_ptr_next_s;
                out_valid_r    <= in_valid;
                out_rob_idx_r  <= rob_idx_s;
                out_fu_r       <= fu_s;
                out_src1_rdy_r <= src1_rdy_s & in_valid;
                out_src2_rdy_r <= src2_rdy_s & in_valid;
            end else begin
                out_valid_r    <= {WIDTH{1'b0}};
                out_rob_idx_r  <= {(WIDTH*RW){1'b0}};
                out_fu_r       <= {(WIDTH*FW){1'b0}};
                out_src1_rdy_r <= {WIDTH{1'b0}};
                out_src2_rdy_r <= {WIDTH{1'b0}};
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_stall_cnt_r;

    // Saturating count of cycles where a non-empty group waits for ROB space.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt_r <= 32'd0;
        end else if ((n_s != {CW{1'b0}}) && !in_ready_s && !flush &&
                     (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
        end else begin
            perf_stall_cnt_r <= perf_stall_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_rob_idx  = out_rob_idx_r;
    assign out_fu       = out_fu_r;
    assign out_src1_rdy = out_src1_rdy_r;
    assign out_src2_rdy = out_src2_rdy_r;
    assign rob_free     = rob_free_r;

    ooo_dispatch_ctrl_chk #(
        .WIDTH     (WIDTH),
        .ROB_DEPTH (ROB_DEPTH),
        .RW        (RW),
        .CW        (CW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .commit_cnt (commit_cnt),
        .rob_free   (rob_free_r)
    );
endmodule

// File: tb/tb_ooo_dispatch_ctrl.sv
// Randomized bench for ooo_dispatch_ctrl against a set/queue-level reference model.
module tb_ooo_dispatch_ctrl;
    localparam int W = 2, PREGS = 64, D = 16, NA = 2, WBP = 2;
    localparam int PRW = 6, RW = 4, FW = 2, CW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0]       in_valid, in_writes_rd, in_uses_imm, in_is_mem;
    logic [W*PRW-1:0]   in_rd, in_rs1, in_rs2;
    logic               in_ready;
    logic [W-1:0]       out_valid, out_src1_rdy, out_src2_rdy;
    logic [W*RW-1:0]    out_rob_idx;
    logic [W*FW-1:0]    out_fu;
    logic [WBP-1:0]     wb_valid;
    logic [WBP*PRW-1:0] wb_preg;
    logic [CW-1:0]      commit_cnt;
    logic               flush;
    logic [RW:0]        rob_free;
`ifdef DISPATCH_PERF_EN
    logic [31:0]        perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ooo_dispatch_ctrl #(.WIDTH(W), .PREGS(PREGS), .ROB_DEPTH(D), .NUM_ALU(NA), .WB_PORTS(WBP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_writes_rd(in_writes_rd), .in_uses_imm(in_uses_imm), .in_is_mem(in_is_mem),
        .in_ready(in_ready), .out_valid(out_valid), .out_rob_idx(out_rob_idx), .out_fu(out_fu),
        .out_src1_rdy(out_src1_rdy), .out_src2_rdy(out_src2_rdy),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .commit_cnt(commit_cnt), .flush(flush),
        .rob_free(rob_free)
`ifdef DISPATCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: ready set, ROB occupancy arithmetic, ALU round-robin pointer.
    bit m_rdy[PREGS];
    int m_head, m_tail, m_free, m_ptr;

    // Stimulus for the next cycle.
    bit s_val[W], s_wr[W], s_imm[W], s_mem[W];
    int s_rd[W], s_rs1[W], s_rs2[W];
    bit s_wbv[WBP];
    int s_wbp[WBP];
    int s_commit;
    bit s_flush;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < W; i++) begin
            s_val[i] = 0; s_wr[i] = 0; s_imm[i] = 0; s_mem[i] = 0;
            s_rd[i] = 0; s_rs1[i] = 0; s_rs2[i] = 0;
        end
        for (int k = 0; k < WBP; k++) begin
            s_wbv[k] = 0; s_wbp[k] = 0;
        end
        s_commit = 0;
        s_flush  = 0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < PREGS; p++) m_rdy[p] = 1;
        m_head = 0; m_tail = 0; m_free = D; m_ptr = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < W; i++) begin
            in_valid[i] = s_val[i]; in_writes_rd[i] = s_wr[i];
            in_uses_imm[i] = s_imm[i]; in_is_mem[i] = s_mem[i];
            in_rd[i*PRW +: PRW]  = PRW'(s_rd[i]);
            in_rs1[i*PRW +: PRW] = PRW'(s_rs1[i]);
            in_rs2[i*PRW +: PRW] = PRW'(s_rs2[i]);
        end
        for (int k = 0; k < WBP; k++) begin
            wb_valid[k] = s_wbv[k];
            wb_preg[k*PRW +: PRW] = PRW'(s_wbp[k]);
        end
        commit_cnt = CW'(s_commit);
        flush = s_flush;
    endtask

    // One cycle: drive, predict, check in_ready, advance clock, check registered outputs.
    task automatic step();
        int n, nalu;
        bit acc;
        bit pend[PREGS];
        bit woke[PREGS];
        bit e_val[W], e_r1[W], e_r2[W];
        int e_idx[W], e_fu[W];
        drive();
        #1;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(s_val[i]);
        acc = !s_flush && (m_free >= n);
        check_val("in_ready", in_ready, acc);
        for (int p = 0; p < PREGS; p++) begin pend[p] = 0; woke[p] = 0; end
        for (int k = 0; k < WBP; k++) if (s_wbv[k]) woke[s_wbp[k]] = 1;
        nalu = 0;
        for (int i = 0; i < W; i++) begin
            e_val[i] = acc && s_val[i];
            e_idx[i] = (m_tail + i) % D;
            if (s_mem[i]) e_fu[i] = NA;
            else begin
                e_fu[i] = (m_ptr + nalu) % NA;
                if (s_val[i]) nalu++;
            end
            e_r1[i] = (s_rs1[i] == 0) || (!pend[s_rs1[i]] && (m_rdy[s_rs1[i]] || woke[s_rs1[i]]));
            e_r2[i] = s_imm[i] || (s_rs2[i] == 0) ||
                      (!pend[s_rs2[i]] && (m_rdy[s_rs2[i]] || woke[s_rs2[i]]));
            if (s_val[i] && s_wr[i]) pend[s_rd[i]] = 1;
        end
        if (s_flush) begin
            m_tail = m_head; m_free = D;
            for (int p = 0; p < PREGS; p++) m_rdy[p] = 1;
        end else begin
            for (int p = 0; p < PREGS; p++) if (woke[p]) m_rdy[p] = 1;
            if (acc) begin
                for (int i = 0; i < W; i++)
                    if (s_val[i] && s_wr[i] && s_rd[i] != 0) m_rdy[s_rd[i]] = 0;
                m_free -= n;
                m_tail = (m_tail + n) % D;
                m_ptr = (m_ptr + nalu) % NA;
            end
            m_free += s_commit;
            m_head = (m_head + s_commit) % D;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            check_val($sformatf("out_valid%0d", i), out_valid[i], e_val[i]);
            if (e_val[i]) begin
                check_val($sformatf("rob_idx%0d", i), out_rob_idx[i*RW +: RW], e_idx[i]);
                check_val($sformatf("fu%0d", i), out_fu[i*FW +: FW], e_fu[i]);
                check_val($sformatf("src1_rdy%0d", i), out_src1_rdy[i], e_r1[i]);
                check_val($sformatf("src2_rdy%0d", i), out_src2_rdy[i], e_r2[i]);
            end
        end
        check_val("rob_free", rob_free, m_free);
        @(negedge clk);
    endtask

    task automatic alu_pair(input int rd0, input int rd1);
        clear_stim();
        s_val[0] = 1; s_val[1] = 1; s_wr[0] = 1; s_wr[1] = 1;
        s_rd[0] = rd0; s_rd[1] = rd1;
        s_rs1[0] = 40; s_rs2[0] = 41; s_rs1[1] = 42; s_rs2[1] = 43;
    endtask

    initial begin
        int occ;
        reset = 1'b1;
        clear_stim();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_rob_free", rob_free, D);
        check_val("reset_in_ready", in_ready, 1);

        // Fill the ROB with eight 2-lane ALU groups, then a ninth must stall.
        for (int g = 0; g < 8; g++) begin
            alu_pair(10 + 2 * g, 11 + 2 * g);
            step();
        end
        check_val("full_free", rob_free, 0);
        alu_pair(30, 31);
        step();

        // Commit two while full: still stalled this cycle, accepted next with wrapped indices.
        s_commit = 2;
        step();
        s_commit = 0;
        step();
        check_val("wrap_idx", out_rob_idx, 8'h10);

        // Clean slate, then intra-group dependency and same-cycle wakeup bypass.
        clear_stim(); s_flush = 1; step();
        clear_stim();
        s_val[0] = 1; s_val[1] = 1; s_wr[0] = 1; s_rd[0] = 5; s_rs1[1] = 5; s_rs2[1] = 7;
        step();
        check_val("dep_src1", out_src1_rdy[1], 0);
        clear_stim();
        s_val[0] = 1; s_rs1[0] = 5; s_imm[0] = 1; s_rs2[0] = 5; s_wbv[0] = 1; s_wbp[0] = 5;
        step();
        check_val("bypass_src1", out_src1_rdy[0], 1);

        // Wakeup and allocation of preg 9 in the same cycle: clear wins.
        clear_stim();
        s_val[0] = 1; s_wr[0] = 1; s_rd[0] = 9; s_wbv[1] = 1; s_wbp[1] = 9;
        step();
        clear_stim();
        s_val[0] = 1; s_rs1[0] = 9;
        step();
        check_val("clear_wins", out_src1_rdy[0], 0);

        // {mem, alu} with alu_ptr = 1.
        if (m_ptr == 0) begin
            clear_stim(); s_val[0] = 1; step();
        end
        clear_stim();
        s_val[0] = 1; s_val[1] = 1; s_mem[0] = 1;
        step();
        check_val("fu_mem_alu", out_fu, 4'b0110);

        // Five entries in flight, then flush with a full group offered.
        clear_stim(); s_flush = 1; step();
        alu_pair(20, 21); step();
        alu_pair(22, 23); step();
        clear_stim(); s_val[0] = 1; s_wr[0] = 1; s_rd[0] = 24; step();
        alu_pair(25, 26); s_flush = 1; step();
        check_val("flush_valid", out_valid, 0);
        check_val("flush_free", rob_free, D);
        clear_stim();
        s_val[0] = 1; s_val[1] = 1; s_rs1[0] = 20; s_rs2[0] = 22; s_rs1[1] = 24; s_rs2[1] = 21;
        step();
        check_val("flush_rdy", {out_src1_rdy, out_src2_rdy}, 4'b1111);

        // Reset in the middle of dispatch.
        alu_pair(27, 28);
        drive();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_free", rob_free, D);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            int n;
            clear_stim();
            n = $urandom_range(0, W);
            for (int i = 0; i < W; i++) begin
                s_val[i] = (i < n);
                s_wr[i]  = $urandom_range(0, 3) != 0;
                s_imm[i] = $urandom_range(0, 3) == 0;
                s_mem[i] = $urandom_range(0, 2) == 0;
                s_rd[i]  = $urandom_range(0, 15);
                s_rs1[i] = $urandom_range(0, 15);
                s_rs2[i] = $urandom_range(0, 15);
            end
            for (int k = 0; k < WBP; k++) begin
                s_wbv[k] = $urandom_range(0, 2) == 0;
                s_wbp[k] = $urandom_range(0, 15);
            end
            occ = D - m_free;
            s_commit = $urandom_range(0, (occ < W) ? occ : W);
            if ($urandom_range(0, 9) < 3) s_commit = 0;
            s_flush = $urandom_range(0, 29) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
